text_blitter: RTL and testbench

Hardware clear/scroll engine and port arbiter for the 8 KB text video memory. It owns the CPU-side port of the dual-port video RAM. The VGA scanout keeps its own port. The CPU has absolute priority on the port, and the engine uses only the cycles the CPU leaves free. Its purpose is to remove the 4000-byte software loops for clear-screen and scroll-up from the AVR firmware.

---
 rtl/text_blitter.sv | 159 +++++++++++++++
 tb/tb_text_blitter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_blitter.sv
// text_blitter: clear/scroll engine sharing the CPU-side port of the text video RAM.
// The CPU always wins the port; the engine advances only in cycles the CPU leaves free.
module text_blitter #(
    parameter int          COLS_BYTES   = 160,
    parameter int          SCREEN_BYTES = 4000,
    parameter logic [12:0] BASE         = 13'h000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        cmd_start,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  fill_char,
    input  logic [7:0]  fill_attr,
    output logic        busy,
    output logic        done,
    input  logic [12:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic [12:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    localparam logic [12:0] END_ADDR = BASE + 13'(SCREEN_BYTES);
    localparam logic [12:0] ROW_OFF  = 13'(COLS_BYTES);
    localparam logic [12:0] LAST_ROW = END_ADDR - ROW_OFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD,
        S_LAT,
        S_WR
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] dst_q, dst_d;
    logic [12:0] end_q, end_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  attr_q, attr_d;
    logic [7:0]  hold_q, hold_d;
    logic        done_q, done_d;
    logic        cpu_ready_q;

    logic        cpu_req;
    logic        free;
    logic [12:0] eng_addr;
    logic [7:0]  eng_wdata;
    logic        eng_we;

    assign cpu_req = cpu_we | cpu_rd;
    assign free    = ~cpu_req;

    // Engine next-state, datapath updates and engine-side port request
    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        end_d     = end_q;
        char_d    = char_q;
        attr_d    = attr_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        eng_addr  = dst_q;
        eng_wdata = hold_q;
        eng_we    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    char_d = fill_char;
                    attr_d = fill_attr;
                    case (cmd_op)
                        2'd0: begin
                            state_d = S_FILL;
                            dst_d   = BASE;
                            end_d   = END_ADDR;
                        end
                        2'd1: begin
                            state_d = S_RD;
                            dst_d   = BASE;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            S_FILL: begin
                eng_we    = 1'b1;
                eng_wdata = dst_q[0] ? attr_q : char_q;
                if (free) begin
                    dst_d = dst_q + 13'd1;
                    if (dst_q + 13'd1 == end_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                eng_addr = dst_q + ROW_OFF;
                if (free) begin
                    state_d = S_LAT;
                end
            end
            S_LAT: begin
                hold_d  = mem_rdata;
                state_d = S_WR;
            end
            S_WR: begin
                eng_we = 1'b1;
                if (free) begin
                    dst_d = dst_q + 13'd1;
                    if (dst_q + 13'd1 == LAST_ROW) begin
                        state_d = S_FILL;
                        end_d   = END_ADDR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            dst_q       <= '0;
            end_q       <= '0;
            char_q      <= '0;
            attr_q      <= '0;
            hold_q      <= '0;
            done_q      <= 1'b0;
            cpu_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            end_q       <= end_d;
            char_q      <= char_d;
            attr_q      <= attr_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            cpu_ready_q <= cpu_req;
        end
    end

    // Engine writes are suppressed while RESET is high so an abort lands no write on its edge
    assign mem_address = cpu_req ? cpu_address : eng_addr;
    assign mem_wdata   = cpu_req ? cpu_wdata   : eng_wdata;
    assign mem_we      = cpu_req ? cpu_we      : (eng_we & ~RESET);

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_text_blitter.sv
// tb_text_blitter: bench for text_blitter with a synchronous RAM model and a CPU-access scoreboard.
module tb_text_blitter;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        cmd_start;
    logic [1:0]  cmd_op;
    logic [7:0]  fill_char;
    logic [7:0]  fill_attr;
    logic        busy;
    logic        done;
    logic [12:0] cpu_address;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_rd;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [12:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    text_blitter #(
        .COLS_BYTES  (160),
        .SCREEN_BYTES(4000),
        .BASE        (13'h000)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .cmd_start  (cmd_start),
        .cmd_op     (cmd_op),
        .fill_char  (fill_char),
        .fill_attr  (fill_attr),
        .busy       (busy),
        .done       (done),
        .cpu_address(cpu_address),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLOCK = ~CLOCK;

    // RAM model: synchronous read, write on clock edge, bulk preload on request
    logic [7:0] ram [0:8191];
    logic [7:0] snap [0:8191];
    int         eng_wr = 0;
    int         done_cnt = 0;
    logic       pl_req = 1'b0;
    int         pl_mode = 0;

    always @(posedge CLOCK) begin
        if (pl_req) begin
            for (int i = 0; i < 8192; i++) begin
                if (pl_mode == 0)      ram[i] <= 8'($urandom);
                else if (pl_mode == 1) ram[i] <= 8'(i);
                else                   ram[i] <= 8'hEE;
            end
        end else if (mem_we) begin
            ram[mem_address] <= mem_wdata;
            if (mem_address < 13'h1000) eng_wr <= eng_wr + 1;
        end
        mem_rdata <= ram[mem_address];
    end

    // done pulse counter, sampled away from the active edge
    always @(negedge CLOCK) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        bit         is_rd;
        logic [7:0] data;
    } cpu_exp_t;

    cpu_exp_t   sb_q[$];
    logic [7:0] shadow [0:255];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input int mode);
        @(negedge CLOCK);
        pl_mode = mode;
        pl_req  = 1'b1;
        @(negedge CLOCK);
        pl_req  = 1'b0;
        for (int i = 0; i < 8192; i++) snap[i] = ram[i];
        for (int i = 0; i < 256; i++) shadow[i] = ram[13'h1000 + i];
    endtask

    function automatic int clear_bad(input logic [7:0] ch, input logic [7:0] at, input int upto);
        int bad = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i < upto) begin
                if (ram[i] !== ((i % 2 == 0) ? ch : at)) bad++;
            end else if (ram[i] !== snap[i]) bad++;
        end
        return bad;
    endfunction

    function automatic int scroll_bad(input logic [7:0] ch, input logic [7:0] at);
        int bad = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] e;
            if (i < 3840) e = 8'(i + 160);
            else          e = (i % 2 == 0) ? ch : at;
            if (ram[i] !== e) bad++;
        end
        return bad;
    endfunction

    function automatic int tail_bad(input int lo, input int hi);
        int bad = 0;
        for (int i = lo; i < hi; i++) if (ram[i] !== snap[i]) bad++;
        return bad;
    endfunction

    function automatic int shadow_bad();
        int bad = 0;
        for (int i = 0; i < 256; i++) if (ram[13'h1000 + i] !== shadow[i]) bad++;
        return bad;
    endfunction

    // Pop the expectation for an access issued last cycle and compare
    task automatic sb_pop();
        cpu_exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("cpu_ready", cpu_ready, 1);
            if (e.is_rd) check("cpu_rdata", cpu_rdata, e.data);
        end
    endtask

    // Issue a command and follow it to completion; a slot model predicts the busy length
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] ch, input logic [7:0] at,
                           input bit traffic, input int ign_at,
                           output int busy_cyc, output int exp_cyc, output int done_t);
        int total;
        int m;
        int stolen;
        bit acc;
        total = (op == 2'd0) ? 4000 : (op == 2'd1) ? 11680 : 0;
        m = 0;
        stolen = 0;
        busy_cyc = 0;
        done_t = -1;
        @(negedge CLOCK);
        cmd_op = op;
        fill_char = ch;
        fill_attr = at;
        cmd_start = 1'b1;
        @(negedge CLOCK);
        cmd_start = 1'b0;
        for (int t = 0; t < 40000; t++) begin
            sb_pop();
            if (done === 1'b1) begin
                done_t = t;
                break;
            end
            if (busy === 1'b1) busy_cyc++;
            acc = traffic && (t % 3 == 0);
            cpu_rd = 1'b0;
            cpu_we = 1'b0;
            if (acc) begin
                int kind;
                int off;
                cpu_exp_t e;
                kind = $urandom_range(0, 2);
                off  = $urandom_range(0, 255);
                cpu_address = 13'h1000 + 13'(off);
                cpu_wdata = 8'($urandom);
                e.is_rd = (kind == 0);
                e.data  = shadow[off];
                if (kind == 0) cpu_rd = 1'b1;
                else begin
                    cpu_we = 1'b1;
                    cpu_rd = (kind == 2);
                    shadow[off] = cpu_wdata;
                end
                sb_q.push_back(e);
            end
            if (t == ign_at) begin
                cmd_op = 2'd0;
                cmd_start = 1'b1;
            end else begin
                cmd_op = op;
                cmd_start = 1'b0;
            end
            if (m < total) begin
                if (acc && !(op == 2'd1 && m < 11520 && m % 3 == 1)) stolen++;
                else m++;
            end
            @(negedge CLOCK);
        end
        cpu_rd = 1'b0;
        cpu_we = 1'b0;
        cmd_start = 1'b0;
        exp_cyc = total + stolen;
        check("done_seen", (done_t >= 0) ? 1 : 0, 1);
        @(negedge CLOCK);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int bc, ec, dt, w0, d0;
        RESET = 1'b1;
        cmd_start = 1'b0;
        cmd_op = 2'd0;
        fill_char = '0;
        fill_attr = '0;
        cpu_address = '0;
        cpu_wdata = '0;
        cpu_we = 1'b0;
        cpu_rd = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_mem_we", mem_we, 0);
        RESET = 1'b0;

        // CLEAR without traffic
        preload(0);
        w0 = eng_wr; d0 = done_cnt;
        run_cmd(2'd0, 8'h20, 8'h17, 1'b0, -1, bc, ec, dt);
        check("clr_busy_cycles", bc, 4000);
        check("clr_model_cycles", bc, ec);
        check("clr_writes", eng_wr - w0, 4000);
        check("clr_bytes_bad", clear_bad(8'h20, 8'h17, 4000), 0);
        check("clr_tail_bad", tail_bad(4000, 8192), 0);
        check("clr_done_pulses", done_cnt - d0, 1);

        // SCROLL_UP without traffic, with a CLEAR strobe mid-scroll that must be ignored
        preload(1);
        d0 = done_cnt;
        run_cmd(2'd1, 8'h00, 8'h07, 1'b0, 500, bc, ec, dt);
        check("scr_busy_cycles", bc, 11680);
        check("scr_bytes_bad", scroll_bad(8'h00, 8'h07), 0);
        check("scr_tail_bad", tail_bad(4000, 8192), 0);
        check("scr_done_pulses", done_cnt - d0, 1);

        // SCROLL_UP with CPU traffic every third cycle at 0x1000+
        preload(1);
        d0 = done_cnt;
        run_cmd(2'd1, 8'h00, 8'h07, 1'b1, -1, bc, ec, dt);
        check("cont_busy_cycles", bc, ec);
        check("cont_bytes_bad", scroll_bad(8'h00, 8'h07), 0);
        check("cont_palette_bad", tail_bad(4000, 4096), 0);
        check("cont_cpu_region_bad", shadow_bad(), 0);
        check("cont_done_pulses", done_cnt - d0, 1);
        check("cont_sb_drained", sb_q.size(), 0);

        // RESET 100 cycles into a CLEAR
        preload(2);
        w0 = eng_wr; d0 = done_cnt;
        @(negedge CLOCK);
        cmd_op = 2'd0;
        fill_char = 8'h41;
        fill_attr = 8'h1E;
        cmd_start = 1'b1;
        @(negedge CLOCK);
        cmd_start = 1'b0;
        check("rmc_busy_started", busy, 1);
        repeat (100) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        check("rmc_busy", busy, 0);
        repeat (3) @(negedge CLOCK);
        check("rmc_no_done", done_cnt - d0, 0);
        check("rmc_writes", eng_wr - w0, 100);
        check("rmc_bytes_bad", clear_bad(8'h41, 8'h1E, 100), 0);
        w0 = eng_wr;
        run_cmd(2'd0, 8'h41, 8'h1E, 1'b0, -1, bc, ec, dt);
        check("rmc_reclear_cycles", bc, 4000);
        check("rmc_reclear_bytes_bad", clear_bad(8'h41, 8'h1E, 4000), 0);

        // Reserved op
        w0 = eng_wr; d0 = done_cnt;
        run_cmd(2'd2, 8'h55, 8'hAA, 1'b0, -1, bc, ec, dt);
        check("rsv_busy_cycles", bc, 0);
        check("rsv_done_time", dt, 0);
        check("rsv_writes", eng_wr - w0, 0);
        check("rsv_done_pulses", done_cnt - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
